// File: rtl/lamp_bus_arbiter.sv
// lamp_bus_arbiter: round-robin owner of the lamp-card parallel bus with timed setup/strobe/hold/turnaround cycles
module lamp_bus_arbiter #(
  parameter int SETUP_CYCLES      = 3,
  parameter int STROBE_CYCLES     = 6,
  parameter int HOLD_CYCLES       = 3,
  parameter int TURNAROUND_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  req_rnw,
  input  logic [11:0] req_board,
  input  logic [8:0]  req_addr,
  input  logic [23:0] req_wdata,
  output logic [2:0]  done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [3:0]  BOARD_X,
  output logic [2:0]  AddessPortPin,
  output logic [7:0]  Data_Out_Port,
  output logic        data_dir,
  input  logic [7:0]  Data_In_Port,
  output logic        RdP,
  output logic        WrP
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;
  localparam int CW = 8;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] ptr, ptr_nx, gnt, gnt_nx, pick, p1, p2;
  logic last;
  logic rnw_q;
  logic [3:0] board_q;
  logic [2:0] addr_q;
  logic [7:0] wdata_q;
  function automatic logic [1:0] nxt(input logic [1:0] v);
    return v == 2'd2 ? 2'd0 : v + 2'd1;
  endfunction
  assign last = cnt == '0;
  assign busy = state != IDLE;
  always_comb begin
    p1 = nxt(ptr);
    p2 = nxt(p1);
    pick = req[ptr] ? ptr : req[p1] ? p1 : p2;
  end
  always_comb begin
    state_nx = state;
    cnt_nx = last ? cnt : cnt - 1'b1;
    ptr_nx = ptr;
    gnt_nx = gnt;
    unique case (state)
      IDLE: if (|req) begin
        state_nx = SETUP;
        cnt_nx = CW'(SETUP_CYCLES - 1);
        gnt_nx = pick;
        ptr_nx = nxt(pick);
      end
      SETUP: if (last) begin
        state_nx = STROBE;
        cnt_nx = CW'(STROBE_CYCLES - 1);
      end
      STROBE: if (last) begin
        state_nx = HOLD;
        cnt_nx = CW'(HOLD_CYCLES - 1);
      end
      HOLD: if (last) begin
        state_nx = TURN;
        cnt_nx = CW'(TURNAROUND_CYCLES - 1);
      end
      TURN: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Pin outputs are registered from the current state, so they trail the FSM by one clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      gnt <= '0;
      rnw_q <= 1'b0;
      board_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      BOARD_X <= '0;
      AddessPortPin <= '0;
      Data_Out_Port <= '0;
      rdata <= '0;
      done <= '0;
      data_dir <= 1'b0;
      RdP <= 1'b1;
      WrP <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ptr <= ptr_nx;
      gnt <= gnt_nx;
      if (state == IDLE && |req) begin
        rnw_q <= req_rnw[pick];
        board_q <= req_board[4*int'(pick) +: 4];
        addr_q <= req_addr[3*int'(pick) +: 3];
        wdata_q <= req_wdata[8*int'(pick) +: 8];
      end
      if (state != IDLE) begin
        BOARD_X <= board_q;
        AddessPortPin <= addr_q;
      end
      if (state == SETUP && !rnw_q) Data_Out_Port <= wdata_q;
      if (state == STROBE && last && rnw_q) rdata <= Data_In_Port;
      data_dir <= !rnw_q && (state inside {SETUP, STROBE, HOLD});
      RdP <= !(rnw_q && state == STROBE);
      WrP <= !(!rnw_q && state == STROBE);
      done <= (state == TURN && cnt == CW'(TURNAROUND_CYCLES - 1)) ? 3'b001 << gnt : 3'b000;
    end
  end
endmodule
